// File: rtl/sync_fetch_ncl.sv
// Clocked instruction-fetch stage feeding the NCL controller stage.
// Reads one 8-bit instruction per fetch from a synchronous memory and presents it
// as a dual-rail word with a four-phase return-to-NULL handshake. The handshake
// is paced by the controller's asynchronous acknowledge, synchronised locally.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   en              fetch enable (sampled in IDLE only)
//   pc_load(_val)   load program counter (honoured in IDLE only, beats en)
//   imem_addr/rd    memory address (= pc) and one-cycle read strobe
//   imem_data       memory read data, valid the cycle after imem_rd
//   instruction     16-bit dual-rail word: bit k -> [2k+1] true rail, [2k] false rail
//   ack_pos         asynchronous acknowledge from the controller stage
//   pc              current program counter
//   busy            high in every state except IDLE
//   proto_err       sticky handshake-violation flag
//
// SYNC_STAGES must be at least 2.
module sync_fetch_ncl #(
    parameter int unsigned            ADDR_W      = 8,
    parameter logic [ADDR_W-1:0]      RESET_PC    = '0,
    parameter int unsigned            SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [7:0]        imem_data,
    output logic [15:0]       instruction,
    input  logic              ack_pos,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned INSN_W = 2 * DATA_W;
    localparam int unsigned WIN_W  = $clog2(SYNC_STAGES + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_DATA,
        S_NULLW
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [INSN_W-1:0]        insn_q, insn_d;
    logic                     rd_q, rd_d;
    logic                     busy_q, busy_d;
    logic                     perr_q, perr_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     ack_s_q;
    logic [WIN_W-1:0]         win_q, win_d;
    logic                     ack_s;
    logic                     ack_rise;

    // One rail of each pair high: true rail carries the bit, false rail its inverse.
    function automatic logic [INSN_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [INSN_W-1:0] w;
        w = '0;
        for (int k = 0; k < DATA_W; k++) begin
            w[2*k+1] = d[k];
            w[2*k]   = ~d[k];
        end
        return w;
    endfunction

    // Acknowledge synchroniser; only the last stage is used by the FSM.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], ack_pos};
    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign ack_rise = ack_s & ~ack_s_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            insn_q  <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
            sync_q  <= '0;
            ack_s_q <= 1'b0;
            win_q   <= WIN_W'(SYNC_STAGES + 1);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
            sync_q  <= sync_d;
            ack_s_q <= ack_s;
            win_q   <= win_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        perr_d  = perr_q;
        // Post-reset window in which a stale acknowledge may still surface.
        win_d   = (win_q != '0) ? win_q - WIN_W'(1) : win_q;

        unique case (state_q)
            S_IDLE: begin
                insn_d = '0;
                if (pc_load) begin
                    pc_d = pc_load_val;
                end else if (en && !ack_s) begin
                    state_d = S_READ;
                end
                // No word is outstanding here, so a new acknowledge is a violation.
                if (ack_rise && (win_q == '0)) begin
                    perr_d = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_CAPT;
                if (ack_rise) begin
                    perr_d = 1'b1;
                end
            end
            S_CAPT: begin
                insn_d  = encode(imem_data);
                state_d = S_DATA;
                if (ack_rise) begin
                    perr_d = 1'b1;
                end
            end
            S_DATA: begin
                if (ack_s) begin
                    insn_d  = '0;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_NULLW;
                end
            end
            S_NULLW: begin
                insn_d = '0;
                if (!ack_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                insn_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Strobe and busy follow the state being entered so they line up with it.
        rd_d   = (state_d == S_READ);
        busy_d = (state_d != S_IDLE);
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign imem_rd     = rd_q;
    assign instruction = insn_q;
    assign busy        = busy_q;
    assign proto_err   = perr_q;

endmodule
